// File: rtl/store_rmw_unit_pkg.sv
// Shared store-path definitions: funct3 store modes, FSM states and the
// halfword offset that cannot be handled by the single-word RMW.
package store_pkg;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  localparam logic [1:0] MISALIGNED_H = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    FAULT
  } state_t;

endpackage

// File: rtl/store_rmw_unit_merge.sv
// Combinational lane merge: places a store byte/half into the old word at the
// byte offset, mirroring the load path's extraction placement.
module store_merge
  import store_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic [2:0]         addrmode,
  input  logic [1:0]         offset,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [D_WIDTH-1:0] old_word,
  output logic [D_WIDTH-1:0] new_word
);

  logic [D_WIDTH-1:0] mask;
  logic [D_WIDTH-1:0] lane_mask;
  logic [4:0]         shamt;

  always_comb begin
    shamt = {offset, 3'b000};
    case (addrmode)
      SB:      mask = {{(D_WIDTH-8){1'b0}}, 8'hFF};
      SH:      mask = {{(D_WIDTH-16){1'b0}}, 16'hFFFF};
      default: begin
        mask  = '1;
        shamt = '0;
      end
    endcase
    lane_mask = mask << shamt;
    new_word  = (old_word & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit for a word-only RAM: sw writes directly, sb/sh do a
// read-merge-write of the aligned word; misaligned halfwords are dropped.
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         addrmode,
  input  logic [A_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] wdata,
  output logic [A_WIDTH-1:0] ram_addr,
  output logic               ram_ren,
  input  logic [D_WIDTH-1:0] ram_rdata,
  output logic               ram_wen,
  output logic [D_WIDTH-1:0] ram_wdata,
  output logic               done,
  output logic               misaligned
);

  state_t             state_q, state_d;
  logic [2:0]         mode_q, mode_d;
  logic [1:0]         off_q, off_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [D_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [D_WIDTH-1:0] merged;

  store_merge #(.D_WIDTH(D_WIDTH)) u_merge (
    .addrmode (mode_q),
    .offset   (off_q),
    .wdata    (wdata_q),
    .old_word (ram_rdata),
    .new_word (merged)
  );

  assign req_ready  = (state_q == IDLE) && !rst;
  assign ram_ren    = (state_q == READ);
  assign ram_wen    = (state_q == WRITE);
  assign done       = (state_q == WRITE);
  assign misaligned = (state_q == FAULT);
  assign ram_addr   = addr_q;
  assign ram_wdata  = ram_wdata_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          mode_d  = addrmode;
          off_d   = addr[1:0];
          wdata_d = wdata;
          addr_d  = {addr[A_WIDTH-1:2], 2'b00};
          if (addrmode == SB) begin
            state_d = READ;
          end else if (addrmode == SH) begin
            state_d = (addr[1:0] == MISALIGNED_H) ? FAULT : READ;
          end else begin
            // sw and unknown modes bypass the read and write the full word
            state_d     = WRITE;
            ram_wdata_d = wdata;
          end
        end
      end
      READ:  state_d = MERGE;
      MERGE: begin
        ram_wdata_d = merged;
        state_d     = WRITE;
      end
      WRITE:   state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed self-checking bench for store_rmw_unit with a one-word RAM stub.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  addrmode = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] ram_addr;
  logic        ram_ren;
  logic [31:0] ram_rdata = '0;
  logic        ram_wen;
  logic [31:0] ram_wdata;
  logic        done;
  logic        misaligned;

  logic [31:0] ram_word = '0;
  int          checks = 0;
  int          errors = 0;
  int          overlap = 0;
  int          wen_seen = 0;

  store_rmw_unit #(.D_WIDTH(32), .A_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .addrmode   (addrmode),
    .addr       (addr),
    .wdata      (wdata),
    .ram_addr   (ram_addr),
    .ram_ren    (ram_ren),
    .ram_rdata  (ram_rdata),
    .ram_wen    (ram_wen),
    .ram_wdata  (ram_wdata),
    .done       (done),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= ram_ren ? ram_word : 32'h0;
  end

  always @(negedge clk) begin
    if (ram_ren && ram_wen) overlap++;
    if (ram_wen) wen_seen++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    addrmode  = m;
    addr      = a;
    wdata     = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst got %b exp 0", req_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if ({ram_ren, ram_wen, done, misaligned} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got %b exp 0000", {ram_ren, ram_wen, done, misaligned});
    end
    checks++;
    if (ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_regs got addr %h wdata %h exp 0 0", ram_addr, ram_wdata);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_sw(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_addr);
    drive(m, a, d);
    tick();
    req_valid = 1'b0;
    checks++;
    if ({ram_wen, done, ram_ren} !== 3'b110) begin
      errors++; $display("FAIL sw_strobes got wen,done,ren=%b exp 110", {ram_wen, done, ram_ren});
    end
    checks++;
    if (ram_addr !== exp_addr || ram_wdata !== d) begin
      errors++; $display("FAIL sw_write got %h:%h exp %h:%h", ram_addr, ram_wdata, exp_addr, d);
    end
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL sw_busy_ready got %b exp 0", req_ready); end
    tick();
    checks++;
    if (req_ready !== 1'b1 || ram_wen !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL sw_return got ready,wen,done=%b exp 100", {req_ready, ram_wen, done});
    end
  endtask

  task automatic test_rmw(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] old, input logic [31:0] exp_addr,
                          input logic [31:0] exp_word);
    ram_word = old;
    drive(m, a, d);
    tick();
    req_valid = 1'b0;
    checks++;
    if (ram_ren !== 1'b1 || ram_wen !== 1'b0 || ram_addr !== exp_addr) begin
      errors++; $display("FAIL rmw_read got ren=%b wen=%b addr=%h exp 1 0 %h", ram_ren, ram_wen, ram_addr, exp_addr);
    end
    tick();
    checks++;
    if (ram_ren !== 1'b0 || ram_wen !== 1'b0 || done !== 1'b0 || ram_addr !== exp_addr) begin
      errors++; $display("FAIL rmw_merge got ren=%b wen=%b done=%b addr=%h exp 0 0 0 %h", ram_ren, ram_wen, done, ram_addr, exp_addr);
    end
    tick();
    checks++;
    if (ram_wen !== 1'b1 || done !== 1'b1 || ram_ren !== 1'b0) begin
      errors++; $display("FAIL rmw_write_strobes got wen,done,ren=%b exp 110", {ram_wen, done, ram_ren});
    end
    checks++;
    if (ram_addr !== exp_addr || ram_wdata !== exp_word) begin
      errors++; $display("FAIL rmw_word got %h:%h exp %h:%h", ram_addr, ram_wdata, exp_addr, exp_word);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || ram_wen !== 1'b0) begin
      errors++; $display("FAIL rmw_return got ready=%b wen=%b exp 1 0", req_ready, ram_wen);
    end
  endtask

  task automatic test_fault;
    int wen0;
    wen0 = wen_seen;
    drive(3'b001, 32'h0000_0303, 32'h0000_BEEF);
    tick();
    req_valid = 1'b0;
    checks++;
    if ({misaligned, ram_ren, ram_wen, done} !== 4'b1000) begin
      errors++; $display("FAIL fault_pulse got mis,ren,wen,done=%b exp 1000", {misaligned, ram_ren, ram_wen, done});
    end
    tick();
    checks++;
    if ({req_ready, misaligned, ram_ren, ram_wen} !== 4'b1000) begin
      errors++; $display("FAIL fault_return got ready,mis,ren,wen=%b exp 1000", {req_ready, misaligned, ram_ren, ram_wen});
    end
    checks++;
    if (wen_seen != wen0) begin errors++; $display("FAIL fault_no_write got %0d writes exp 0", wen_seen - wen0); end
  endtask

  task automatic test_reset_mid;
    int wen0;
    wen0 = wen_seen;
    ram_word = 32'h1122_3344;
    drive(3'b000, 32'h0000_0500, 32'h0000_00EE);
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({ram_ren, ram_wen, done, req_ready} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_idle got ren,wen,done,ready=%b exp 0000", {ram_ren, ram_wen, done, req_ready});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", req_ready); end
    tick();
    tick();
    checks++;
    if (wen_seen != wen0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_write got %0d writes done=%b exp 0 0", wen_seen - wen0, done);
    end
  endtask

  task automatic test_back_to_back;
    ram_word = 32'hAABB_CCDD;
    drive(3'b000, 32'h0000_0104, 32'h0000_0077);
    tick();
    drive(3'b010, 32'h0000_0108, 32'h1234_5678);
    checks++;
    if (ram_ren !== 1'b1 || ram_addr !== 32'h104) begin
      errors++; $display("FAIL b2b_sb_read got ren=%b addr=%h exp 1 104", ram_ren, ram_addr);
    end
    tick();
    tick();
    checks++;
    if (ram_wen !== 1'b1 || ram_wdata !== 32'hAABB_CC77 || req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_sb_write got wen=%b data=%h ready=%b exp 1 aabbcc77 0", ram_wen, ram_wdata, req_ready);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || ram_wen !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got ready=%b wen=%b exp 1 0", req_ready, ram_wen);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (ram_wen !== 1'b1 || ram_addr !== 32'h108 || ram_wdata !== 32'h1234_5678 || ram_ren !== 1'b0) begin
      errors++; $display("FAIL b2b_sw_write got wen=%b ren=%b %h:%h exp 1 0 108:12345678", ram_wen, ram_ren, ram_addr, ram_wdata);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_sw(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100);
    test_rmw(3'b000, 32'h0000_0102, 32'h0000_00AB, 32'h1122_3344, 32'h0000_0100, 32'h11AB_3344);
    test_rmw(3'b001, 32'h0000_0201, 32'h0000_CAFE, 32'h1122_3344, 32'h0000_0200, 32'h11CA_FE44);
    test_rmw(3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'h1122_3344, 32'h0000_0200, 32'hBEEF_3344);
    test_rmw(3'b001, 32'h0000_0600, 32'hFFFF_5A5A, 32'h1122_3344, 32'h0000_0600, 32'h1122_5A5A);
    test_rmw(3'b000, 32'h0000_0703, 32'hFFFF_FF99, 32'h1122_3344, 32'h0000_0700, 32'h9922_3344);
    test_sw(3'b111, 32'h0000_040F, 32'hCAFE_F00D, 32'h0000_040C);
    test_fault();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL ren_wen_overlap got %0d cycles exp 0", overlap); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
